// File: rtl/flit_inject_fifo.sv
// Injection FIFO between a non-stallable flit source and the router local port.
// First-word-fall-through storage with saturating delivered/dropped counters and a sticky overflow flag.
module flit_inject_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [CNT_W-1:0]           inj_count,
   output logic [CNT_W-1:0]           drop_count,
   output logic                       overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [LVL_W-1:0] level_r;
   logic [CNT_W-1:0] inj_cnt_r;
   logic [CNT_W-1:0] drop_cnt_r;
   logic             overflow_r;
   logic             full_s;
   logic             empty_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH-1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1'b1);
      end
   endfunction

   assign full_s  = (level_r == LVL_W'(DEPTH));
   assign empty_s = (level_r == {LVL_W{1'b0}});
   assign pop_s   = !empty_s && out_ready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign push_s  = in_valid && (!full_s || pop_s);
   assign drop_s  = in_valid && full_s && !pop_s;

   assign out_data   = mem_r[rd_ptr_r];
   assign out_valid  = !empty_s;
   assign full       = full_s;
   assign empty      = empty_s;
   assign level      = level_r;
   assign inj_count  = inj_cnt_r;
   assign drop_count = drop_cnt_r;
   assign overflow   = overflow_r;

   // Flit storage; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= {PTR_W{1'b0}};
         wr_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {LVL_W{1'b0}};
      end else begin
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LVL_W'(1'b1);
            2'b01:   level_r <= level_r - LVL_W'(1'b1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Saturating statistics and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_cnt_r  <= {CNT_W{1'b0}};
         drop_cnt_r <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (pop_s && (inj_cnt_r != {CNT_W{1'b1}})) begin
            inj_cnt_r <= inj_cnt_r + CNT_W'(1'b1);
         end
         if (drop_s && (drop_cnt_r != {CNT_W{1'b1}})) begin
            drop_cnt_r <= drop_cnt_r + CNT_W'(1'b1);
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_flit_inject_fifo.sv
// Directed self-checking bench for flit_inject_fifo: DEPTH=8 main instance plus a CNT_W=4 instance for saturation.
module tb_flit_inject_fifo;

   logic        clk;
   logic        rst;
   logic [19:0] in_data;
   logic        in_valid;
   logic        out_ready;

   logic [19:0] out_data;
   logic        out_valid;
   logic        full;
   logic        empty;
   logic [3:0]  level;
   logic [15:0] inj_count;
   logic [15:0] drop_count;
   logic        overflow;

   logic [19:0] s_out_data;
   logic        s_out_valid;
   logic        s_full;
   logic        s_empty;
   logic [3:0]  s_level;
   logic [3:0]  s_inj_count;
   logic [3:0]  s_drop_count;
   logic        s_overflow;

   int          chk_cnt;
   int          pass_cnt;
   logic [19:0] model_q [$];

   flit_inject_fifo #(.WIDTH(20), .DEPTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .full(full), .empty(empty), .level(level),
      .inj_count(inj_count), .drop_count(drop_count), .overflow(overflow)
   );

   flit_inject_fifo #(.WIDTH(20), .DEPTH(8), .CNT_W(4)) u_dut_sat (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .full(s_full), .empty(s_empty), .level(s_level),
      .inj_count(s_inj_count), .drop_count(s_drop_count), .overflow(s_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      if (obs === exp) begin
         pass_cnt = pass_cnt + 1;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle of stimulus; head flit and occupancy compared to a queue model.
   task automatic drive(input logic v, input logic [19:0] d, input logic r);
      logic pop_m;
      logic push_m;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
         check_eq("out_data", {12'd0, out_data}, {12'd0, model_q[0]});
      end
      pop_m  = r && (model_q.size() != 0);
      push_m = v && ((model_q.size() < 8) || pop_m);
      @(posedge clk);
      #1;
      if (pop_m) begin
         void'(model_q.pop_front());
      end
      if (push_m) begin
         model_q.push_back(d);
      end
      check_eq("level", {28'd0, level}, model_q.size());
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_q.delete();
   endtask

   initial begin
      chk_cnt   = 0;
      pass_cnt  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 20'h00000;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Test 1: make counters/flags nonzero, then asynchronous reset mid-cycle.
      for (int i = 0; i < 9; i++) drive(1'b1, 20'h01011 + 20'(i * 16), 1'b0);
      drive(1'b0, 20'h00000, 1'b1);
      check_eq("pre_rst_drop", {16'd0, drop_count}, 32'd1);
      check_eq("pre_rst_inj", {16'd0, inj_count}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_level", {28'd0, level}, 32'd0);
      check_eq("rst_empty", {31'd0, empty}, 32'd1);
      check_eq("rst_full", {31'd0, full}, 32'd0);
      check_eq("rst_inj", {16'd0, inj_count}, 32'd0);
      check_eq("rst_drop", {16'd0, drop_count}, 32'd0);
      check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_q.delete();

      // Test 2: 30 back-to-back flits with out_ready=1.
      for (int i = 0; i < 30; i++) drive(1'b1, 20'h03011 + 20'(i * 16), 1'b1);
      drive(1'b0, 20'h00000, 1'b1);
      check_eq("t2_inj", {16'd0, inj_count}, 32'd30);
      check_eq("t2_drop", {16'd0, drop_count}, 32'd0);
      check_eq("t2_empty", {31'd0, empty}, 32'd1);

      // Test 3: overfill with out_ready=0, then drain.
      pulse_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, 20'h03011 + 20'(i * 16), 1'b0);
      check_eq("t3_full", {31'd0, full}, 32'd1);
      check_eq("t3_level", {28'd0, level}, 32'd8);
      check_eq("t3_drop", {16'd0, drop_count}, 32'd2);
      check_eq("t3_overflow", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         check_eq("t3_head", {12'd0, out_data}, {12'd0, 20'h03011 + 20'(i * 16)});
         drive(1'b0, 20'h00000, 1'b1);
      end
      check_eq("t3_empty", {31'd0, empty}, 32'd1);
      check_eq("t3_inj", {16'd0, inj_count}, 32'd8);
      check_eq("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

      // Test 4: full FIFO with simultaneous push and pop.
      pulse_reset();
      for (int i = 0; i < 8; i++) drive(1'b1, 20'h04011 + 20'(i * 16), 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 20'h05011 + 20'(i * 16), 1'b1);
         check_eq("t4_level", {28'd0, level}, 32'd8);
      end
      check_eq("t4_drop", {16'd0, drop_count}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (i < 3) check_eq("t4_old", {12'd0, out_data}, {12'd0, 20'h04061 + 20'(i * 16)});
         else       check_eq("t4_new", {12'd0, out_data}, {12'd0, 20'h05011 + 20'((i - 3) * 16)});
         drive(1'b0, 20'h00000, 1'b1);
      end
      check_eq("t4_empty", {31'd0, empty}, 32'd1);

      // Test 5: reset discards buffered flits.
      pulse_reset();
      for (int i = 0; i < 3; i++) drive(1'b1, 20'h0B011 + 20'(i * 16), 1'b0);
      pulse_reset();
      check_eq("t5_post_rst_valid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, 20'h0AAA1, 1'b0);
      check_eq("t5_head", {12'd0, out_data}, 32'h0AAA1);
      check_eq("t5_level", {28'd0, level}, 32'd1);
      drive(1'b0, 20'h00000, 1'b1);
      check_eq("t5_empty", {31'd0, empty}, 32'd1);

      // Test 6: saturation on the CNT_W=4 instance.
      pulse_reset();
      for (int i = 0; i < 20; i++) drive(1'b1, 20'h06011 + 20'(i * 16), 1'b1);
      drive(1'b0, 20'h00000, 1'b1);
      check_eq("t6_inj_sat", {28'd0, s_inj_count}, 32'd15);
      check_eq("t6_inj_wide", {16'd0, inj_count}, 32'd20);
      check_eq("t6_sat_empty", {31'd0, s_empty}, 32'd1);
      pulse_reset();
      for (int i = 0; i < 30; i++) drive(1'b1, 20'h07011 + 20'(i * 16), 1'b0);
      check_eq("t6_drop_sat", {28'd0, s_drop_count}, 32'd15);
      check_eq("t6_drop_wide", {16'd0, drop_count}, 32'd22);
      check_eq("t6_sat_full", {31'd0, s_full}, 32'd1);
      check_eq("t6_sat_level", {28'd0, s_level}, 32'd8);
      check_eq("t6_sat_valid", {31'd0, s_out_valid}, 32'd1);
      check_eq("t6_sat_overflow", {31'd0, s_overflow}, 32'd1);
      check_eq("t6_sat_head", {12'd0, s_out_data}, 32'h07011);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
